ram_sp_arbiter: RTL and testbench

// - Shares one single-port write-first RAM (ram_sp_wf) between two requesters: port A (CSR-to-RAM bridge, RAM side) and port B (HW engine).
// - Accepts at most one access per cycle and arbitrates round-robin.
// - Supports a lock for atomic read-modify-write sequences, with a bounded lock length.
// - Tags in-flight reads so each read result returns only to its owner.
//

---
 rtl/ram_sp_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_sp_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_arbiter.sv
// Two-port round-robin arbiter in front of a single-port write-first RAM, with bounded
// locking for atomic sequences and owner-tagged read return. Macro: RAM_SP_ARBITER_FIXED_PRIO_EN.
module ram_sp_arbiter #(
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int WORD_ADDR_BIT_WIDTH = 3,
  parameter int USE_RAM_OUTPUT_REG  = 1,
  parameter int MAX_LOCK_LEN        = 16
) (
  input  logic                             i_clk,
  input  logic                             i_async_rst_n,
  input  logic                             i_a_req,
  input  logic                             i_a_we,
  input  logic                             i_a_lock,
  input  logic [WORD_ADDR_BIT_WIDTH-1:0]   i_a_word_addr,
  input  logic [WORD_BIT_WIDTH-1:0]        i_a_wr_data,
  input  logic [WORD_BIT_WIDTH/8-1:0]      i_a_wr_byte_en,
  input  logic                             i_b_req,
  input  logic                             i_b_we,
  input  logic                             i_b_lock,
  input  logic [WORD_ADDR_BIT_WIDTH-1:0]   i_b_word_addr,
  input  logic [WORD_BIT_WIDTH-1:0]        i_b_wr_data,
  input  logic [WORD_BIT_WIDTH/8-1:0]      i_b_wr_byte_en,
  output logic                             o_a_gnt,
  output logic                             o_a_rd_vld,
  output logic [WORD_BIT_WIDTH-1:0]        o_a_rd_data,
  output logic                             o_b_gnt,
  output logic                             o_b_rd_vld,
  output logic [WORD_BIT_WIDTH-1:0]        o_b_rd_data,
  output logic                             o_ram_we,
  output logic [WORD_ADDR_BIT_WIDTH-1:0]   o_ram_word_addr,
  output logic [WORD_BIT_WIDTH-1:0]        o_ram_wr_data,
  output logic [WORD_BIT_WIDTH/8-1:0]      o_ram_wr_byte_en,
  input  logic [WORD_BIT_WIDTH-1:0]        i_ram_rd_data,
  output logic [1:0]                       o_dbg_state
);

  // Handshake: a port raises req and holds its command until gnt is seen high in the same
  // cycle; gnt doubles as the write ack, and a granted read returns RD_LAT cycles later.
  localparam int RD_LAT = 1 + USE_RAM_OUTPUT_REG;
  localparam int CNT_W  = $clog2(MAX_LOCK_LEN + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_A = 2'd1;
  localparam logic [1:0] LOCK_B = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             gnt_a, gnt_b;
  logic [RD_LAT-1:0] pipe_vld, pipe_own;
`ifndef RAM_SP_ARBITER_FIXED_PRIO_EN
  logic             last_gnt; // 1 = B was granted last
`endif

  // Grants are gated by reset so every output sits at 0 while reset is held.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (i_async_rst_n) begin
      case (state)
        LOCK_A: gnt_a = i_a_req;
        LOCK_B: gnt_b = i_b_req;
        default: begin
          if (i_a_req && i_b_req) begin
`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
            gnt_a = 1'b1;
`else
            gnt_a = last_gnt;
            gnt_b = ~last_gnt;
`endif
          end else begin
            gnt_a = i_a_req;
            gnt_b = i_b_req;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      IDLE: begin
        if (gnt_a && i_a_lock) begin
          state_nxt    = LOCK_A;
          lock_cnt_nxt = CNT_W'(1);
        end else if (gnt_b && i_b_lock) begin
          state_nxt    = LOCK_B;
          lock_cnt_nxt = CNT_W'(1);
        end
      end
      LOCK_A: begin
        // This grant would bring the count to MAX_LOCK_LEN: release is forced.
        if (!i_a_req || !i_a_lock || lock_cnt == CNT_W'(MAX_LOCK_LEN - 1)) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      LOCK_B: begin
        if (!i_b_req || !i_b_lock || lock_cnt == CNT_W'(MAX_LOCK_LEN - 1)) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

`ifndef RAM_SP_ARBITER_FIXED_PRIO_EN
  // Any release of a lock leaves last_gnt on the lock owner, so the other port wins the next tie.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      last_gnt <= 1'b1;
    end else if (gnt_a) begin
      last_gnt <= 1'b0;
    end else if (gnt_b) begin
      last_gnt <= 1'b1;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld[0] <= (gnt_a & ~i_a_we) | (gnt_b & ~i_b_we);
      pipe_own[0] <= gnt_b;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign o_a_gnt          = gnt_a;
  assign o_b_gnt          = gnt_b;
  assign o_ram_we         = (gnt_a & i_a_we) | (gnt_b & i_b_we);
  assign o_ram_word_addr  = gnt_a ? i_a_word_addr  : (gnt_b ? i_b_word_addr  : '0);
  assign o_ram_wr_data    = gnt_a ? i_a_wr_data    : (gnt_b ? i_b_wr_data    : '0);
  assign o_ram_wr_byte_en = gnt_a ? i_a_wr_byte_en : (gnt_b ? i_b_wr_byte_en : '0);
  assign o_a_rd_vld       = pipe_vld[RD_LAT-1] & ~pipe_own[RD_LAT-1];
  assign o_b_rd_vld       = pipe_vld[RD_LAT-1] &  pipe_own[RD_LAT-1];
  assign o_a_rd_data      = i_ram_rd_data;
  assign o_b_rd_data      = i_ram_rd_data;
  assign o_dbg_state      = state;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter with a behavioural write-first RAM (output register on).
module tb_ram_sp_arbiter;

  localparam int W  = 32;
  localparam int AW = 3;
  localparam int BW = W / 8;
`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 0, a_we = 0, a_lock = 0;
  logic [AW-1:0] a_addr = '0;
  logic [W-1:0]  a_wdata = '0;
  logic [BW-1:0] a_be = '0;
  logic          b_req = 0, b_we = 0, b_lock = 0;
  logic [AW-1:0] b_addr = '0;
  logic [W-1:0]  b_wdata = '0;
  logic [BW-1:0] b_be = '0;
  logic          a_gnt, a_rd_vld, b_gnt, b_rd_vld;
  logic [W-1:0]  a_rd_data, b_rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata, ram_rdata;
  logic [BW-1:0] ram_be;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$]; // {owner(1=B), data}

  always #5 clk = ~clk;

  ram_sp_arbiter dut (
    .i_clk(clk), .i_async_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_lock(a_lock), .i_a_word_addr(a_addr),
    .i_a_wr_data(a_wdata), .i_a_wr_byte_en(a_be),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_lock(b_lock), .i_b_word_addr(b_addr),
    .i_b_wr_data(b_wdata), .i_b_wr_byte_en(b_be),
    .o_a_gnt(a_gnt), .o_a_rd_vld(a_rd_vld), .o_a_rd_data(a_rd_data),
    .o_b_gnt(b_gnt), .o_b_rd_vld(b_rd_vld), .o_b_rd_data(b_rd_data),
    .o_ram_we(ram_we), .o_ram_word_addr(ram_addr), .o_ram_wr_data(ram_wdata),
    .o_ram_wr_byte_en(ram_be), .i_ram_rd_data(ram_rdata), .o_dbg_state(dbg_state)
  );

  // Behavioural write-first RAM, two-cycle read latency.
  function automatic logic [W-1:0] pat(input int a);
    return 32'h1111_1111 * 32'(a + 1);
  endfunction

  logic [W-1:0] mem [8];
  logic [W-1:0] merged, q1, q2;
  logic         ram_load = 1'b1;

  always_comb begin
    merged = mem[ram_addr];
    for (int i = 0; i < BW; i++)
      if (ram_be[i]) merged[i*8 +: 8] = ram_wdata[i*8 +: 8];
  end

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 8; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      mem[ram_addr] <= merged;
    end
    q1 <= ram_we ? merged : mem[ram_addr];
    q2 <= q1;
  end
  assign ram_rdata = q2;

  task automatic clear_inputs();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0; b_be = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ram_load = 0;
    a_req = 1; a_we = 1; a_addr = 3'd6; a_wdata = 32'hFFFF_FFFF; a_be = '1;
    b_req = 1; b_addr = 3'd2;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL rst_gnt got=%b exp=00", {a_gnt, b_gnt});
    end
    n_checks++;
    if ({ram_we, ram_addr, ram_wdata, ram_be} !== '0) begin
      n_fail++; $display("FAIL rst_ram_cmd got=%h exp=0", {ram_we, ram_addr, ram_wdata, ram_be});
    end
    n_checks++;
    if ({a_rd_vld, b_rd_vld, dbg_state} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_vld_state got=%b exp=0000", {a_rd_vld, b_rd_vld, dbg_state});
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 3'd3;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt, ram_we, ram_addr} !== {3'b100, 3'd3}) begin
      n_fail++; $display("FAIL t1_grant got=%b exp=100011", {a_gnt, b_gnt, ram_we, ram_addr});
    end
    @(negedge clk);
    a_req = 0;
    #1;
    n_checks++;
    if (a_rd_vld !== 1'b0) begin
      n_fail++; $display("FAIL t1_vld_early got=%b exp=0", a_rd_vld);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_rd_vld, b_rd_vld} !== 2'b10) begin
      n_fail++; $display("FAIL t1_vld got=%b exp=10", {a_rd_vld, b_rd_vld});
    end
    n_checks++;
    if (a_rd_data !== pat(3)) begin
      n_fail++; $display("FAIL t1_data got=%h exp=%h", a_rd_data, pat(3));
    end
  endtask

  task automatic test_round_robin();
    logic [W:0] e;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) begin
        a_req = 1; a_we = 0; a_addr = AW'(i);
        b_req = 1; b_we = 0; b_addr = AW'(i + 4);
      end else begin
        clear_inputs();
      end
      #1;
      if (i < 8) begin
        n_checks++;
        if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", i, {a_gnt, b_gnt},
                             (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        exp_q.push_back((i % 2 == 0) ? {1'b0, pat(i % 8)} : {1'b1, pat((i + 4) % 8)});
      end
      if (i >= 2) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({a_rd_vld, b_rd_vld} !== {~e[W], e[W]} || a_rd_data !== e[W-1:0]) begin
          n_fail++; $display("FAIL rr_return cyc=%0d got=%b/%h exp=%b/%h", i, {a_rd_vld, b_rd_vld},
                             a_rd_data, {~e[W], e[W]}, e[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_fixed_prio();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_req = 1; b_req = 1; a_addr = AW'(i); b_addr = AW'(i);
      #1;
      n_checks++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
        n_fail++; $display("FAIL fp_gnt cyc=%0d got=%b exp=10", i, {a_gnt, b_gnt});
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_lock_rmw();
    @(negedge clk);
    a_req = 1; a_we = 0; a_lock = 1; a_addr = 3'd5;
    b_req = 1; b_we = 0; b_addr = 3'd5;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL lk_c0_gnt got=%b exp=10", {a_gnt, b_gnt});
    end
    @(negedge clk);
    a_we = 1; a_lock = 0; a_wdata = 32'hDEAD_BEEF; a_be = '1;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt, dbg_state, ram_we} !== 5'b10011) begin
      n_fail++; $display("FAIL lk_c1_gnt got=%b exp=10011", {a_gnt, b_gnt, dbg_state, ram_we});
    end
    n_checks++;
    if (ram_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lk_c1_wdata got=%h exp=deadbeef", ram_wdata);
    end
    @(negedge clk);
    a_req = 0; a_we = 0;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt, ram_addr} !== {2'b01, 3'd5}) begin
      n_fail++; $display("FAIL lk_c2_gnt got=%b exp=01101", {a_gnt, b_gnt, ram_addr});
    end
    n_checks++;
    if (a_rd_vld !== 1'b1 || a_rd_data !== pat(5)) begin
      n_fail++; $display("FAIL lk_a_read got=%b/%h exp=1/%h", a_rd_vld, a_rd_data, pat(5));
    end
    @(negedge clk);
    b_req = 0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_rd_vld, b_rd_vld} !== 2'b01 || b_rd_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lk_b_read got=%b/%h exp=01/deadbeef", {a_rd_vld, b_rd_vld}, b_rd_data);
    end
  endtask

  task automatic test_forced_release();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_req = 1; a_we = 0; a_lock = 1; a_addr = AW'(i);
      b_req = (i <= 16); b_we = 0; b_addr = 3'd1;
      #1;
      if (i == 16) begin
        n_checks++;
        if ({a_gnt, b_gnt, dbg_state} !== {FIXED_PRIO, ~FIXED_PRIO, 2'b00}) begin
          n_fail++; $display("FAIL fr_release got=%b exp=%b", {a_gnt, b_gnt, dbg_state},
                             {FIXED_PRIO, ~FIXED_PRIO, 2'b00});
        end
      end else begin
        n_checks++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
          n_fail++; $display("FAIL fr_gnt cyc=%0d got=%b exp=10", i, {a_gnt, b_gnt});
        end
      end
    end
    @(negedge clk);
    clear_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    b_req = 1; b_we = 0; b_addr = 3'd4;
    #1;
    n_checks++;
    if (b_gnt !== 1'b1) begin
      n_fail++; $display("FAIL mr_gnt got=%b exp=1", b_gnt);
    end
    @(negedge clk);
    rst_n = 0;
    a_req = 1; a_we = 1; a_addr = 3'd7;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt, a_rd_vld, b_rd_vld, ram_we, ram_addr, dbg_state} !== '0) begin
      n_fail++; $display("FAIL mr_outputs got=%b exp=0",
                         {a_gnt, b_gnt, a_rd_vld, b_rd_vld, ram_we, ram_addr, dbg_state});
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({a_rd_vld, b_rd_vld} !== 2'b00) begin
        n_fail++; $display("FAIL mr_no_vld cyc=%0d got=%b exp=00", i, {a_rd_vld, b_rd_vld});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    do_reset();
`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    do_reset();
    test_lock_rmw();
    do_reset();
    test_forced_release();
    do_reset();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
